// File: rtl/edge_detect_pkg.sv
// Shared constants and helpers for the multi-channel edge detector.
package edge_detect_pkg;

    localparam logic [1:0] EDGE_OFF  = 2'b00;
    localparam logic [1:0] EDGE_RISE = 2'b01;
    localparam logic [1:0] EDGE_FALL = 2'b10;
    localparam logic [1:0] EDGE_BOTH = 2'b11;

    // Widest channel vector popcount accepts; callers zero-extend into it.
    localparam int unsigned POP_MAX_W = 256;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/edge_filter_ch.sv
// One channel: synchroniser chain, glitch filter and edge qualification.
module edge_filter_ch
    import edge_detect_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       prime_i,
    input  logic       din_i,
    input  logic [1:0] mode_i,
    output logic       flag_next_o
);

    localparam int FCW = $clog2(FILTER_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   filt_q, filt_d;
    logic [FCW-1:0]         cnt_q, cnt_d;
    logic                   s;
    logic                   update;
    logic                   rise_en, fall_en;

    assign s       = sync_q[SYNC_STAGES-1];
    assign update  = !prime_i && (s != filt_q) && (cnt_q == FCW'(FILTER_CYCLES - 1));
    assign rise_en = (mode_i == EDGE_RISE) || (mode_i == EDGE_BOTH);
    assign fall_en = (mode_i == EDGE_FALL) || (mode_i == EDGE_BOTH);

    // Mode is looked at only in the cycle the filtered level actually changes.
    assign flag_next_o = update && (s ? rise_en : fall_en);

    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        if (prime_i) begin
            filt_d = s;
            cnt_d  = '0;
        end else if (s == filt_q) begin
            cnt_d  = '0;
        end else if (update) begin
            filt_d = s;
            cnt_d  = '0;
        end else begin
            cnt_d  = cnt_q + FCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel filters plus shared sticky/irq/event-count state.
module edge_detect_multi
    import edge_detect_pkg::*;
#(
    parameter int CHANNELS      = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 3,
    parameter int CNT_W         = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   irq_en,
    input  logic [CHANNELS-1:0]   clr,
    input  logic                  cnt_clr,
    output logic [CHANNELS-1:0]   flag,
    output logic [CHANNELS-1:0]   sticky,
    output logic                  irq,
    output logic [CNT_W-1:0]      evt_count
);

    localparam int PRIME_W = $clog2(SYNC_STAGES + 2);
    localparam int SUM_W   = CNT_W + $clog2(CHANNELS + 1) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    logic [PRIME_W-1:0]  prime_q;
    logic [CHANNELS-1:0] flag_next;
    logic [CHANNELS-1:0] flag_q, sticky_q, sticky_d;
    logic                irq_q;
    logic [CNT_W-1:0]    evt_q, evt_d;
    logic [SUM_W-1:0]    pop_w, base_w, sum_w;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        edge_filter_ch #(
            .SYNC_STAGES   (SYNC_STAGES),
            .FILTER_CYCLES (FILTER_CYCLES)
        ) u_ch (
            .clock       (clock),
            .rst         (rst),
            .prime_i     (prime_q != '0),
            .din_i       (din[i]),
            .mode_i      (mode[2*i+1:2*i]),
            .flag_next_o (flag_next[i])
        );
    end

    // Set beats clear so an edge landing on the clear cycle is never lost.
    assign sticky_d = (sticky_q & ~clr) | flag_next;

    always_comb begin
        pop_w  = SUM_W'(popcount(POP_MAX_W'(flag_next)));
        base_w = cnt_clr ? '0 : SUM_W'(evt_q);
        sum_w  = base_w + pop_w;
        evt_d  = (sum_w > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_w[CNT_W-1:0];
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            prime_q  <= PRIME_W'(SYNC_STAGES + 1);
            flag_q   <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
            evt_q    <= '0;
        end else begin
            if (prime_q != '0) prime_q <= prime_q - PRIME_W'(1);
            flag_q   <= flag_next;
            sticky_q <= sticky_d;
            irq_q    <= |(sticky_q & irq_en);
            evt_q    <= evt_d;
        end
    end

    assign flag      = flag_q;
    assign sticky    = sticky_q;
    assign irq       = irq_q;
    assign evt_count = evt_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench: expectations are queued with a target cycle and checked when it arrives.
module tb_edge_detect_multi;

    localparam int CH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] din, irq_en, clr;
    logic [15:0]   mode;
    logic          cnt_clr;
    logic [CH-1:0] flag, sticky;
    logic          irq;
    logic [3:0]    evt_count;

    edge_detect_multi #(.CHANNELS(CH), .SYNC_STAGES(2), .FILTER_CYCLES(3), .CNT_W(4)) dut (
        .clock(clk), .rst(rst), .din(din), .mode(mode), .irq_en(irq_en), .clr(clr),
        .cnt_clr(cnt_clr), .flag(flag), .sticky(sticky), .irq(irq), .evt_count(evt_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        string       name;
        int          sel;   // 0 flag, 1 sticky, 2 irq, 3 evt_count
        logic [15:0] val;
    } exp_t;

    typedef struct {
        logic [CH-1:0] din;
        logic [CH-1:0] clr;
        logic [CH-1:0] flag;
        logic [CH-1:0] sticky;
        logic          irq;
        logic [3:0]    cnt;
    } vec_t;

    exp_t exq[$];
    vec_t tbl[14];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [15:0] act;
        for (int i = exq.size() - 1; i >= 0; i--) begin
            if (exq[i].cyc == cyc) begin
                case (exq[i].sel)
                    0:       act = 16'(flag);
                    1:       act = 16'(sticky);
                    2:       act = 16'(irq);
                    default: act = 16'(evt_count);
                endcase
                n_tests++;
                if (act !== exq[i].val) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got %0h expected %0h", exq[i].name, cyc, act, exq[i].val);
                end
                exq.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic exp_at(input int d, input string nm, input int sel, input logic [15:0] v);
        exp_t e;
        e.cyc = cyc + d; e.name = nm; e.sel = sel; e.val = v;
        exq.push_back(e);
    endtask

    task automatic exp_all(input int d, input string nm, input logic [CH-1:0] f,
                           input logic [CH-1:0] s, input logic q, input logic [3:0] c);
        exp_at(d, {nm, "_flag"}, 0, 16'(f));
        exp_at(d, {nm, "_sticky"}, 1, 16'(s));
        exp_at(d, {nm, "_irq"}, 2, 16'(q));
        exp_at(d, {nm, "_cnt"}, 3, 16'(c));
    endtask

    initial begin
        // ch0 rise-only: pulse on rise, nothing on fall, then sticky clear.
        for (int j = 0; j < 14; j++) begin
            tbl[j].din    = (j < 6) ? 8'h01 : 8'h00;
            tbl[j].clr    = (j == 12) ? 8'h01 : 8'h00;
            tbl[j].flag   = (j == 4) ? 8'h01 : 8'h00;
            tbl[j].sticky = (j >= 4 && j < 12) ? 8'h01 : 8'h00;
            tbl[j].irq    = (j >= 5 && j < 13);
            tbl[j].cnt    = (j >= 4) ? 4'd1 : 4'd0;
        end

        rst = 1'b1; din = 8'hFF; mode = 16'hFFFF; irq_en = 8'hFF; clr = '0; cnt_clr = 1'b0;
        step(2);
        exp_all(1, "reset", 8'h00, 8'h00, 1'b0, 4'd0);
        step(1);
        rst = 1'b0;

        // Input held high through reset must not look like a rising edge.
        for (int k = 1; k <= 20; k++) exp_at(k, "t1_flag", 0, 16'h0);
        exp_all(20, "t1_end", 8'h00, 8'h00, 1'b0, 4'd0);
        step(20);

        mode = 16'h0; din = 8'h00;
        step(10);
        clr = 8'hFF; cnt_clr = 1'b1;
        step(1);
        clr = '0; cnt_clr = 1'b0;
        step(2);

        mode = 16'h0001; irq_en = 8'h01;
        for (int j = 0; j < 14; j++) begin
            din = tbl[j].din; clr = tbl[j].clr;
            exp_all(1, $sformatf("t2_row%0d", j), tbl[j].flag, tbl[j].sticky, tbl[j].irq, tbl[j].cnt);
            step(1);
        end
        clr = '0;

        // ch1 both edges: 2-cycle glitch rejected, 3-cycle pulse gives rise then fall.
        mode = 16'h000C; irq_en = 8'h00; cnt_clr = 1'b1;
        exp_at(1, "t3_cntclr", 3, 16'h0);
        step(1);
        cnt_clr = 1'b0;
        for (int k = 1; k <= 12; k++) exp_at(k, "t3_glitch", 0, 16'h0);
        exp_at(12, "t3_glitch_cnt", 3, 16'h0);
        din = 8'h02; step(2); din = 8'h00; step(10);
        for (int k = 1; k <= 12; k++) exp_at(k, "t3_pulse", 0, (k == 5 || k == 8) ? 16'h2 : 16'h0);
        exp_at(5, "t3_cnt_rise", 3, 16'd1);
        exp_at(8, "t3_cnt_fall", 3, 16'd2);
        din = 8'h02; step(3); din = 8'h00; step(9);

        // ch2 sticky: set wins over same-edge clear, clear alone drops it.
        clr = 8'hFF; step(1); clr = '0;
        mode = 16'h0010; din = 8'h04;
        exp_at(5, "t4_flag1", 0, 16'h04);
        exp_at(5, "t4_sticky1", 1, 16'h04);
        step(5);
        din = 8'h00;
        for (int k = 1; k <= 8; k++) exp_at(k, "t4_nofall", 0, 16'h0);
        step(8);
        din = 8'h04;
        exp_at(5, "t4_flag2", 0, 16'h04);
        step(4);
        clr = 8'h04;
        exp_at(1, "t4_set_wins", 1, 16'h04);
        step(1);
        clr = '0;
        exp_at(1, "t4_held", 1, 16'h04);
        step(1);
        clr = 8'h04;
        exp_at(1, "t4_clr", 1, 16'h00);
        step(1);
        clr = '0;

        // All channels together against a 4-bit saturating counter.
        mode = 16'h0; din = 8'h00;
        step(8);
        cnt_clr = 1'b1;
        exp_at(1, "t5_clr0", 3, 16'h0);
        step(1);
        cnt_clr = 1'b0;
        mode = 16'hFFFF; din = 8'hFF;
        exp_at(5, "t5_flag_r", 0, 16'hFF);
        exp_at(5, "t5_cnt8", 3, 16'd8);
        step(8);
        din = 8'h00;
        exp_at(5, "t5_flag_f", 0, 16'hFF);
        exp_at(5, "t5_sat", 3, 16'd15);
        step(8);
        din = 8'hFF;
        step(4);
        cnt_clr = 1'b1;
        exp_at(1, "t5_clr_evt", 3, 16'd8);
        step(1);
        cnt_clr = 1'b0;
        step(3);
        cnt_clr = 1'b1;
        exp_at(1, "t5_clr_idle", 3, 16'd0);
        step(1);
        cnt_clr = 1'b0;

        // Reset while the falling edges are two cycles into the filter.
        irq_en = 8'hFF;
        exp_at(2, "t6_pre_irq", 2, 16'h1);
        step(2);
        din = 8'h00;
        exp_at(4, "t6_pre_sticky", 1, 16'hFF);
        step(4);
        rst = 1'b1;
        exp_all(1, "t6_rst", 8'h00, 8'h00, 1'b0, 4'd0);
        step(1);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) exp_at(k, "t6_noflag", 0, 16'h0);
        exp_at(12, "t6_sticky", 1, 16'h0);
        step(14);

        n_tests++;
        if (exq.size() != 0) begin
            n_fail++;
            $display("FAIL pending_checks: got %0d left expected 0", exq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
